softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter: RTL and testbench

Arbitrates single-port access to the 256x32 on-chip debug (OCI) RAM between JTAG debug commands and the CPU's Avalon debug slave. The JTAG path carries one-cycle command pulses from the debug slave's sysclk stage, backed by a one-entry buffer and an auto-incrementing address register. JTAG read data returns on MonDReg for the next JTAG capture. Sits between the debug slave wrapper and the OCI RAM instance, all in the CPU clock domain.

---
 rtl/softproc_debug_pkg.sv | 20 ++
 rtl/softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter_if.sv | 24 ++
 rtl/softproc_nios2_gen2_0_cpu_debug_jtag_cmd_buf.sv | 85 ++++++++
 rtl/softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter.sv | 126 ++++++++++++
 tb/tb_softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/softproc_debug_pkg.sv
// Shared constants for the Nios II debug OCI RAM arbiter: sizes, FSM encoding, grant owners.
package softproc_debug_pkg;

    localparam int unsigned RAM_AW_DEF = 8;
    localparam int unsigned DW_DEF     = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        CAPTURE = ST_CAPTURE
    } arb_state_e;

    localparam logic GRANT_CPU  = 1'b0;
    localparam logic GRANT_JTAG = 1'b1;

endpackage

// File: rtl/softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter_if.sv
// Avalon debug-slave bundle between the CPU (master) and the OCI RAM arbiter (slave).
interface softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter_if
    import softproc_debug_pkg::*;
#(
    parameter int unsigned RAM_AW = RAM_AW_DEF,
    parameter int unsigned DW     = DW_DEF
);
    logic [RAM_AW-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DW-1:0]     avs_writedata;
    logic [DW-1:0]     avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/softproc_nios2_gen2_0_cpu_debug_jtag_cmd_buf.sv
// One-entry JTAG command buffer with auto-incrementing address, overrun flag,
// MonDReg capture and monitor_ready status.
module softproc_nios2_gen2_0_cpu_debug_jtag_cmd_buf
    import softproc_debug_pkg::*;
#(
    parameter int unsigned RAM_AW = RAM_AW_DEF,
    parameter int unsigned DW     = DW_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_cmd_valid,
    input  logic              jtag_cmd_addr_load,
    input  logic              jtag_cmd_write,
    input  logic [RAM_AW-1:0] jtag_cmd_addr,
    input  logic [DW-1:0]     jtag_cmd_wdata,
    input  logic              jtag_clr_err,
    input  logic              i_done,
    input  logic              i_done_rd,
    input  logic [DW-1:0]     i_ram_rdata,
    output logic              o_req_c,
    output logic              o_write_c,
    output logic [DW-1:0]     o_wdata_c,
    output logic [RAM_AW-1:0] o_jaddr,
    output logic [DW-1:0]     MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);
    logic              r_buf_full;
    logic              r_write;
    logic [DW-1:0]     r_wdata;
    logic [RAM_AW-1:0] r_jaddr;
    logic              w_accept;
    logic              w_drop;
    logic              w_acc_access;
    logic              w_acc_load;

    // The completion cycle frees the slot, so a command landing there is taken.
    assign w_accept     = jtag_cmd_valid && (!r_buf_full || i_done);
    assign w_drop       = jtag_cmd_valid && r_buf_full && !i_done;
    assign w_acc_access = w_accept && !jtag_cmd_addr_load;
    assign w_acc_load   = w_accept && jtag_cmd_addr_load;

    // A fresh pulse is visible to the arbiter in the same cycle it arrives.
    assign o_req_c   = r_buf_full || w_acc_access;
    assign o_write_c = r_buf_full ? r_write : jtag_cmd_write;
    assign o_wdata_c = r_buf_full ? r_wdata : jtag_cmd_wdata;
    assign o_jaddr   = r_jaddr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_buf_full    <= 1'b0;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_jaddr       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            jtag_overrun  <= 1'b0;
        end else begin
            if (i_done) begin
                r_buf_full    <= 1'b0;
                r_jaddr       <= r_jaddr + RAM_AW'(1);
                monitor_ready <= 1'b1;
            end
            if (w_acc_access) begin
                r_buf_full    <= 1'b1;
                r_write       <= jtag_cmd_write;
                r_wdata       <= jtag_cmd_wdata;
                monitor_ready <= 1'b0;
            end
            if (w_acc_load) begin
                r_jaddr <= jtag_cmd_addr;
            end
            if (i_done_rd) begin
                MonDReg <= i_ram_rdata;
            end
            if (jtag_clr_err) begin
                jtag_overrun <= 1'b0;
            end
            if (w_drop) begin
                jtag_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI debug RAM between JTAG commands
// and the CPU Avalon debug slave.
module softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter
    import softproc_debug_pkg::*;
#(
    parameter int unsigned RAM_AW = RAM_AW_DEF,
    parameter int unsigned DW     = DW_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              jtag_cmd_valid,
    input  logic              jtag_cmd_addr_load,
    input  logic              jtag_cmd_write,
    input  logic [RAM_AW-1:0] jtag_cmd_addr,
    input  logic [DW-1:0]     jtag_cmd_wdata,
    input  logic              jtag_clr_err,
    softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter_if.slave avs,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DW-1:0]     ram_rdata,
    output logic [DW-1:0]     MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);
    arb_state_e        r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_write;
    logic              r_waitreq;
    logic              w_jtag_req;
    logic              w_jtag_write;
    logic [DW-1:0]     w_jtag_wdata;
    logic [RAM_AW-1:0] w_jaddr;
    logic              w_cpu_req;
    logic              w_grant;
    logic              w_sel_write;
    logic              w_jtag_done;
    logic              w_jtag_done_rd;

    softproc_nios2_gen2_0_cpu_debug_jtag_cmd_buf #(
        .RAM_AW (RAM_AW),
        .DW     (DW)
    ) u_cmd_buf (
        .clk                (clk),
        .reset_n            (reset_n),
        .jtag_cmd_valid     (jtag_cmd_valid),
        .jtag_cmd_addr_load (jtag_cmd_addr_load),
        .jtag_cmd_write     (jtag_cmd_write),
        .jtag_cmd_addr      (jtag_cmd_addr),
        .jtag_cmd_wdata     (jtag_cmd_wdata),
        .jtag_clr_err       (jtag_clr_err),
        .i_done             (w_jtag_done),
        .i_done_rd          (w_jtag_done_rd),
        .i_ram_rdata        (ram_rdata),
        .o_req_c            (w_jtag_req),
        .o_write_c          (w_jtag_write),
        .o_wdata_c          (w_jtag_wdata),
        .o_jaddr            (w_jaddr),
        .MonDReg            (MonDReg),
        .monitor_ready      (monitor_ready),
        .jtag_overrun       (jtag_overrun)
    );

    assign w_cpu_req   = avs.avs_read || avs.avs_write;
    assign w_grant     = (w_cpu_req && w_jtag_req) ? ~r_last_grant :
                         (w_jtag_req ? GRANT_JTAG : GRANT_CPU);
    assign w_sel_write = (w_grant == GRANT_CPU) ? avs.avs_write : w_jtag_write;

    assign w_jtag_done_rd = (r_state == CAPTURE) && (r_owner == GRANT_JTAG);
    assign w_jtag_done    = w_jtag_done_rd ||
                            ((r_state == ISSUE) && (r_owner == GRANT_JTAG) && r_write);

    assign avs.avs_readdata    = ram_rdata;
    assign avs.avs_waitrequest = r_waitreq;

    // RAM strobes and waitrequest are registered on the transition into the cycle they mark.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_owner      <= GRANT_CPU;
            r_last_grant <= GRANT_CPU;
            r_write      <= 1'b0;
            r_waitreq    <= 1'b1;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_we       <= 1'b0;
            ram_re       <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            r_waitreq <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_cpu_req || w_jtag_req) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_write      <= w_sel_write;
                        ram_addr     <= (w_grant == GRANT_CPU) ? avs.avs_address : w_jaddr;
                        ram_wdata    <= (w_grant == GRANT_CPU) ? avs.avs_writedata : w_jtag_wdata;
                        ram_we       <= w_sel_write;
                        ram_re       <= ~w_sel_write;
                        r_waitreq    <= ~((w_grant == GRANT_CPU) && w_sel_write);
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_write) begin
                        r_state <= IDLE;
                    end else begin
                        r_waitreq <= (r_owner != GRANT_CPU);
                        r_state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter.sv
// Self-checking bench: RAM model, scoreboard of expected RAM accesses, directed JTAG/CPU scenarios.
module tb_softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter;

    typedef struct packed {
        logic [7:0]  addr;
        logic        we;
        logic [31:0] wdata;
    } ram_txn_t;

    logic        clk;
    logic        reset_n;
    logic        jtag_cmd_valid;
    logic        jtag_cmd_addr_load;
    logic        jtag_cmd_write;
    logic [7:0]  jtag_cmd_addr;
    logic [31:0] jtag_cmd_wdata;
    logic        jtag_clr_err;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        jtag_overrun;

    softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter_if avs_if ();

    softproc_nios2_gen2_0_cpu_debug_ocimem_arbiter dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .jtag_cmd_valid     (jtag_cmd_valid),
        .jtag_cmd_addr_load (jtag_cmd_addr_load),
        .jtag_cmd_write     (jtag_cmd_write),
        .jtag_cmd_addr      (jtag_cmd_addr),
        .jtag_cmd_wdata     (jtag_cmd_wdata),
        .jtag_clr_err       (jtag_clr_err),
        .avs                (avs_if),
        .ram_addr           (ram_addr),
        .ram_wdata          (ram_wdata),
        .ram_we             (ram_we),
        .ram_re             (ram_re),
        .ram_rdata          (ram_rdata),
        .MonDReg            (MonDReg),
        .monitor_ready      (monitor_ready),
        .jtag_overrun       (jtag_overrun)
    );

    logic [31:0] mem [256];
    logic [31:0] exp_mem [256];
    ram_txn_t    exp_q [$];
    ram_txn_t    mon_txn;
    logic [7:0]  jaddr_m;
    logic [31:0] exp_mon;
    logic        mon_en;
    int          n_checks;
    int          n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 1-cycle synchronous-read RAM.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Every RAM strobe must match the next expected access in order.
    always @(negedge clk) begin
        if (mon_en && (ram_we || ram_re)) begin
            check("ram_one_strobe", 32'(ram_we && ram_re), 32'd0);
            if (exp_q.size() == 0) begin
                check("ram_unexpected_access", 32'(ram_addr), 32'hFFFF_FFFF);
            end else begin
                mon_txn = exp_q.pop_front();
                check("ram_addr", 32'(ram_addr), 32'(mon_txn.addr));
                check("ram_we", 32'(ram_we), 32'(mon_txn.we));
                if (mon_txn.we) check("ram_wdata", ram_wdata, mon_txn.wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic [7:0] a, input logic wr, input logic [31:0] d);
        ram_txn_t t;
        t.addr = a;
        t.we = wr;
        t.wdata = d;
        exp_q.push_back(t);
        if (wr) exp_mem[a] = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        avs_if.avs_read = 1'b0;
        avs_if.avs_write = 1'b0;
        jtag_cmd_valid = 1'b0;
        jtag_clr_err = 1'b0;
        repeat (3) tick();
        check("rst_waitreq", 32'(avs_if.avs_waitrequest), 32'd1);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_re", 32'(ram_re), 32'd0);
        check("rst_mondreg", MonDReg, 32'd0);
        check("rst_ready", 32'(monitor_ready), 32'd0);
        check("rst_overrun", 32'(jtag_overrun), 32'd0);
        reset_n = 1'b1;
        jaddr_m = 8'h00;
    endtask

    task automatic jtag_cmd(input logic ld, input logic wr, input logic [7:0] a, input logic [31:0] d);
        jtag_cmd_valid = 1'b1;
        jtag_cmd_addr_load = ld;
        jtag_cmd_write = wr;
        jtag_cmd_addr = a;
        jtag_cmd_wdata = d;
        tick();
        jtag_cmd_valid = 1'b0;
    endtask

    task automatic jtag_load(input logic [7:0] a);
        jaddr_m = a;
        jtag_cmd(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic jtag_access(input logic wr, input logic [31:0] d);
        if (!wr) exp_mon = exp_mem[jaddr_m];
        push_txn(jaddr_m, wr, d);
        jaddr_m = jaddr_m + 8'd1;
        jtag_cmd(1'b0, wr, 8'h00, d);
    endtask

    task automatic wait_ready(input string tag, input int exp_n);
        int n;
        n = 0;
        while (!monitor_ready && n < 20) begin
            tick();
            n++;
        end
        if (!monitor_ready) check({tag, "_timeout"}, 32'd0, 32'd1);
        else if (exp_n >= 0) check(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic wait_cpu(input string tag, input int exp_lat, output logic [31:0] rd);
        int  c;
        logic done;
        c = 1;
        done = 1'b0;
        rd = '0;
        while (!done && c <= 20) begin
            if (!avs_if.avs_waitrequest) begin
                done = 1'b1;
                rd = avs_if.avs_readdata;
                check({tag, "_lat"}, 32'(c), 32'(exp_lat));
            end
            tick();
            c++;
        end
        avs_if.avs_read = 1'b0;
        avs_if.avs_write = 1'b0;
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic cpu_access(input string tag, input logic wr, input logic [7:0] a,
                              input logic [31:0] d, output logic [31:0] rd);
        avs_if.avs_address = a;
        avs_if.avs_writedata = d;
        avs_if.avs_write = wr;
        avs_if.avs_read = ~wr;
        push_txn(a, wr, d);
        wait_cpu(tag, wr ? 2 : 3, rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat;
        int lows;
        n_checks = 0;
        n_pass = 0;
        mon_en = 1'b0;
        reset_n = 1'b0;
        jtag_cmd_valid = 1'b0;
        jtag_cmd_addr_load = 1'b0;
        jtag_cmd_write = 1'b0;
        jtag_cmd_addr = '0;
        jtag_cmd_wdata = '0;
        jtag_clr_err = 1'b0;
        avs_if.avs_address = '0;
        avs_if.avs_read = 1'b0;
        avs_if.avs_write = 1'b0;
        avs_if.avs_writedata = '0;
        tick();
        mon_en = 1'b1;
        do_reset();

        // Preload and JTAG write/read round trip.
        cpu_access("cpu_wr20", 1'b1, 8'h20, 32'h1234_5678, rd);
        jtag_load(8'h00);
        jtag_access(1'b1, 32'hA5A5_0000);
        wait_ready("j_wr0_lat", 1);
        jtag_load(8'h10);
        jtag_access(1'b1, 32'hDEAD_BEEF);
        wait_ready("j_wr10_lat", 1);
        jtag_load(8'h10);
        jtag_access(1'b0, 32'd0);
        wait_ready("j_rd10_lat", 2);
        check("t1_mondreg", MonDReg, exp_mon);
        check("t1_ready", 32'(monitor_ready), 32'd1);
        jtag_access(1'b0, 32'd0);
        wait_ready("j_rd11_lat", 2);
        cpu_access("cpu_rd10", 1'b0, 8'h10, 32'd0, rd);
        check("cpu_rd10_data", rd, 32'hDEAD_BEEF);
        check("sb_empty_1", 32'(exp_q.size()), 32'd0);

        // Simultaneous requests from reset: JTAG first, CPU completes in cycle 6.
        do_reset();
        avs_if.avs_address = 8'h20;
        avs_if.avs_read = 1'b1;
        jtag_cmd_valid = 1'b1;
        jtag_cmd_addr_load = 1'b0;
        jtag_cmd_write = 1'b0;
        push_txn(8'h00, 1'b0, 32'd0);
        push_txn(8'h20, 1'b0, 32'd0);
        jaddr_m = 8'h01;
        lat = 0;
        lows = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) jtag_cmd_valid = 1'b0;
            if (!avs_if.avs_waitrequest) begin
                lows++;
                lat = c;
                check("t2_rdata", avs_if.avs_readdata, 32'h1234_5678);
            end
            if (c == 4) begin
                check("t2_mondreg", MonDReg, 32'hA5A5_0000);
                check("t2_ready", 32'(monitor_ready), 32'd1);
            end
            tick();
            if (lat != 0) avs_if.avs_read = 1'b0;
        end
        check("t2_cpu_lat", 32'(lat), 32'd6);
        check("t2_wait_lows", 32'(lows), 32'd1);

        // Pulse while buffer busy is dropped; clear; set wins over clear.
        jtag_access(1'b0, 32'd0);
        jtag_cmd(1'b0, 1'b1, 8'h00, 32'h2222_2222);
        check("t3_ovr_set", 32'(jtag_overrun), 32'd1);
        wait_ready("t3_rd", -1);
        check("t3_ovr_sticky", 32'(jtag_overrun), 32'd1);
        jtag_clr_err = 1'b1;
        tick();
        jtag_clr_err = 1'b0;
        check("t3_ovr_clr", 32'(jtag_overrun), 32'd0);
        jtag_access(1'b0, 32'd0);
        jtag_clr_err = 1'b1;
        jtag_cmd(1'b1, 1'b0, 8'h77, 32'd0);
        jtag_clr_err = 1'b0;
        check("t3_set_wins", 32'(jtag_overrun), 32'd1);
        wait_ready("t3_rd2", -1);
        jtag_clr_err = 1'b1;
        tick();
        jtag_clr_err = 1'b0;
        check("t3_ovr_clr2", 32'(jtag_overrun), 32'd0);

        // Second pulse in the completion cycle is accepted.
        jtag_access(1'b1, 32'h3333_3333);
        jtag_access(1'b1, 32'h4444_4444);
        check("t4_no_ovr", 32'(jtag_overrun), 32'd0);
        check("t4_ready_clr", 32'(monitor_ready), 32'd0);
        wait_ready("t4_wr2", -1);
        check("t4_no_ovr_end", 32'(jtag_overrun), 32'd0);
        cpu_access("cpu_rd04", 1'b0, 8'h04, 32'd0, rd);
        check("t4_rd04", rd, 32'h4444_4444);

        // jaddr wraps from 0xFF to 0x00.
        jtag_load(8'hFF);
        jtag_access(1'b1, 32'h0F0F_0F0F);
        wait_ready("t5_wr_ff", 1);
        jtag_access(1'b0, 32'd0);
        wait_ready("t5_rd_00", 2);
        check("t5_wrap_mondreg", MonDReg, 32'hA5A5_0000);
        cpu_access("cpu_rdff", 1'b0, 8'hFF, 32'd0, rd);
        check("t5_rdff", rd, 32'h0F0F_0F0F);

        // Reset during ISSUE of a CPU read; held request then completes normally.
        avs_if.avs_address = 8'h10;
        avs_if.avs_read = 1'b1;
        push_txn(8'h10, 1'b0, 32'd0);
        push_txn(8'h10, 1'b0, 32'd0);
        tick();
        check("t6_re_issue", 32'(ram_re), 32'd1);
        reset_n = 1'b0;
        tick();
        check("t6_waitreq", 32'(avs_if.avs_waitrequest), 32'd1);
        check("t6_ram_re", 32'(ram_re), 32'd0);
        check("t6_ram_we", 32'(ram_we), 32'd0);
        check("t6_mondreg", MonDReg, 32'd0);
        reset_n = 1'b1;
        wait_cpu("t6_cpu", 3, rd);
        check("t6_rdata", rd, 32'hDEAD_BEEF);
        repeat (3) tick();
        check("sb_empty_end", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
